// File: rtl/dirty_flush_ctl.sv
// dirty_flush_ctl
//   Sequencer and write-port owner for the 4-way dirty-bit array.
//   In IDLE the cache pipeline's dirty-bit reads and writes pass straight
//   through to the array. A flush request stalls the pipeline and walks
//   every set. For each dirty way it issues a writeback request
//   (valid/ready), then clears that dirty bit.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   flush_req            one-cycle pulse, starts a flush from IDLE only
//   flush_busy           high in every state except IDLE
//   flush_done           one-cycle pulse when the walk completes
//   core_stall           equals flush_busy
//   core_ra/wa/way/wr/in pipeline dirty-array access (used only in IDLE)
//   d_ra, d_rd           dirty array read address / combinational read data
//   d_wa/d_way/d_wr/d_in dirty array write port
//   wb_valid/wb_ready    writeback request handshake
//   wb_set, wb_way       set and way index being written back
module dirty_flush_ctl #(
  parameter int SETS = 8192,
  parameter int AW   = 13,
  parameter int WAYS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_req,
  output logic            flush_busy,
  output logic            flush_done,
  output logic            core_stall,
  input  logic [AW-1:0]   core_ra,
  input  logic [AW-1:0]   core_wa,
  input  logic [WAYS-1:0] core_way,
  input  logic            core_wr,
  input  logic            core_in,
  output logic [AW-1:0]   d_ra,
  input  logic [WAYS-1:0] d_rd,
  output logic [AW-1:0]   d_wa,
  output logic [WAYS-1:0] d_way,
  output logic            d_wr,
  output logic            d_in,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_set,
  output logic [1:0]      wb_way,
  input  logic            wb_ready
);

  typedef enum logic [2:0] {IDLE, SCAN, WB, CLR, DONE} state_t;

  localparam logic [AW-1:0] LAST_SET = AW'(SETS - 1);

  state_t          state;
  logic [AW-1:0]   set_ctr;
  logic [WAYS-1:0] mask;
  logic [WAYS-1:0] mask_oh;
  logic [WAYS-1:0] mask_rest;
  logic            last_set;

  // Index of the lowest set bit; ways are serviced from way 0 upward.
  function automatic logic [1:0] low_idx(input logic [WAYS-1:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[0])      idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else if (m[3]) idx = 2'd3;
    return idx;
  endfunction

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [WAYS-1:0] low_onehot(input logic [WAYS-1:0] m);
    return m & (~m + WAYS'(1));
  endfunction

  assign mask_oh   = low_onehot(mask);
  assign mask_rest = mask & ~mask_oh;
  assign last_set  = (set_ctr == LAST_SET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      set_ctr <= '0;
      mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state   <= SCAN;
            set_ctr <= '0;
          end
        end
        SCAN: begin
          if (d_rd != '0) begin
            mask  <= d_rd;
            state <= WB;
          end else if (last_set) begin
            state <= DONE;
          end else begin
            set_ctr <= set_ctr + AW'(1);
          end
        end
        WB: begin
          if (wb_ready) state <= CLR;
        end
        CLR: begin
          mask <= mask_rest;
          // Last-set check comes before any increment so set_ctr never wraps.
          if (mask_rest != '0) begin
            state <= WB;
          end else if (last_set) begin
            state <= DONE;
          end else begin
            set_ctr <= set_ctr + AW'(1);
            state   <= SCAN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only the state register, so wb_valid has no path from
  // wb_ready, and reset clears them asynchronously through state.
  always_comb begin
    d_ra       = set_ctr;   // must track d_wa: the array merges using rd of ra
    d_wa       = set_ctr;
    d_way      = '0;
    d_wr       = 1'b0;
    d_in       = 1'b0;
    wb_valid   = 1'b0;
    wb_set     = set_ctr;
    wb_way     = low_idx(mask);
    flush_busy = (state != IDLE);
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        d_ra  = core_ra;
        d_wa  = core_wa;
        d_way = core_way;
        d_wr  = core_wr;
        d_in  = core_in;
      end
      WB:   wb_valid = 1'b1;
      CLR: begin
        d_wr  = 1'b1;
        d_way = mask_oh;
      end
      DONE: flush_done = 1'b1;
      default: ;
    endcase
  end

  assign core_stall = flush_busy;

endmodule

// File: tb/tb_dirty_flush_ctl.sv
module tb_dirty_flush_ctl;
  localparam int SETS = 8192;
  localparam int AW   = 13;
  localparam int WAYS = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush_req = 1'b0;
  logic            flush_busy, flush_done, core_stall;
  logic [AW-1:0]   core_ra = '0, core_wa = '0;
  logic [WAYS-1:0] core_way = '0;
  logic            core_wr = 1'b0, core_in = 1'b0;
  logic [AW-1:0]   d_ra, d_wa;
  logic [WAYS-1:0] d_rd, d_way;
  logic            d_wr, d_in;
  logic            wb_valid;
  logic [AW-1:0]   wb_set;
  logic [1:0]      wb_way;
  logic            wb_ready = 1'b0;

  int total = 0;
  int bad = 0;

  dirty_flush_ctl #(.SETS(SETS), .AW(AW), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .core_stall(core_stall),
    .core_ra(core_ra), .core_wa(core_wa), .core_way(core_way),
    .core_wr(core_wr), .core_in(core_in),
    .d_ra(d_ra), .d_rd(d_rd), .d_wa(d_wa), .d_way(d_way),
    .d_wr(d_wr), .d_in(d_in),
    .wb_valid(wb_valid), .wb_set(wb_set), .wb_way(wb_way), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  // Dirty array model: combinational read, per-bit write on the clock.
  logic [WAYS-1:0] arr [0:SETS-1];
  logic            clr_all = 1'b0;
  logic            pre_we = 1'b0;
  logic [AW-1:0]   pre_a = '0;
  logic [WAYS-1:0] pre_v = '0;

  assign d_rd = arr[d_ra];

  always @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < SETS; i++) arr[i] <= '0;
    end else if (pre_we) begin
      arr[pre_a] <= pre_v;
    end else if (d_wr) begin
      arr[d_wa] <= (arr[d_wa] & ~d_way) | (d_in ? d_way : 4'b0000);
    end
  end

  // Monitor sampled on the falling edge.
  logic        mon_clr = 1'b0;
  int          mon_wb, mon_dwr, mon_done, mon_overlap, mon_unstable, hs_n;
  logic [AW-1:0] hs_set [0:7];
  logic [1:0]    hs_way [0:7];
  logic          prev_stall;
  logic [AW-1:0] prev_set;
  logic [1:0]    prev_way;

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_wb <= 0; mon_dwr <= 0; mon_done <= 0; mon_overlap <= 0;
      mon_unstable <= 0; hs_n <= 0; prev_stall <= 1'b0;
    end else begin
      if (wb_valid) mon_wb <= mon_wb + 1;
      if (d_wr) mon_dwr <= mon_dwr + 1;
      if (flush_done) mon_done <= mon_done + 1;
      if (flush_done && wb_valid) mon_overlap <= mon_overlap + 1;
      if (prev_stall && (!wb_valid || wb_set != prev_set || wb_way != prev_way))
        mon_unstable <= mon_unstable + 1;
      prev_stall <= wb_valid && !wb_ready;
      prev_set   <= wb_set;
      prev_way   <= wb_way;
      if (wb_valid && wb_ready) begin
        if (hs_n < 8) begin
          hs_set[hs_n] <= wb_set;
          hs_way[hs_n] <= wb_way;
        end
        hs_n <= hs_n + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WAYS-1:0] v);
    pre_a = a; pre_v = v; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic pulse_mon_clr();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  // Runs one flush. stall = ready-low cycles per request (0 = ready tied 1).
  // dup_at / cwr_at: cycle numbers for a repeated flush_req / a core write.
  task automatic run_flush(input int stall, input int dup_at, input int cwr_at,
                           output int cyc, output int busy_n, output int stall_diff);
    int  wctr;
    bit  done_seen;
    wctr = 0; cyc = 0; busy_n = 0; stall_diff = 0; done_seen = 1'b0;
    pulse_mon_clr();
    flush_req = 1'b1;
    wb_ready  = (stall == 0);
    while (!done_seen && cyc < 20000) begin
      tick();
      cyc++;
      flush_req = (cyc == dup_at);
      core_wr   = 1'b0;
      if (flush_busy) busy_n++;
      if (core_stall !== flush_busy) stall_diff++;
      if (flush_done) done_seen = 1'b1;
      if (stall != 0) begin
        if (wb_valid) begin
          if (wctr == stall) begin wb_ready = 1'b1; wctr = 0; end
          else begin wb_ready = 1'b0; wctr++; end
        end else begin
          wb_ready = 1'b0;
        end
      end
      if (cyc == cwr_at) begin
        core_wa = 13'd7; core_way = 4'b0100; core_in = 1'b1; core_wr = 1'b1;
        #1;
        check("core_wr_blocked_d_wr", {31'd0, d_wr}, 32'd0);
        check("core_wr_blocked_stall", {31'd0, core_stall}, 32'd1);
      end
    end
    if (!done_seen) check("flush_timeout", 32'd0, 32'd1);
    tick();
    core_wr = 1'b0;
    check("busy_after_done", {31'd0, flush_busy}, 32'd0);
    wb_ready = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0]   ra, wa;
    logic [WAYS-1:0] way;
    logic            wr, cin;
    logic [31:0]     exp;   // {d_ra, d_wa, d_way, d_wr, d_in}
  } vec_t;

  vec_t vecs [0:5];
  int   cyc, busy_n, stall_diff;
  bit   seen;

  initial begin
    vecs[0] = '{13'h0000, 13'h0000, 4'b0000, 1'b0, 1'b0, {13'h0000, 13'h0000, 4'b0000, 1'b0, 1'b0}};
    vecs[1] = '{13'h1FFF, 13'h0AAA, 4'b0001, 1'b0, 1'b1, {13'h1FFF, 13'h0AAA, 4'b0001, 1'b0, 1'b1}};
    vecs[2] = '{13'h1234, 13'h0555, 4'b1000, 1'b0, 1'b0, {13'h1234, 13'h0555, 4'b1000, 1'b0, 1'b0}};
    vecs[3] = '{13'h0007, 13'h0007, 4'b0100, 1'b1, 1'b1, {13'h0007, 13'h0007, 4'b0100, 1'b1, 1'b1}};
    vecs[4] = '{13'h0007, 13'h0010, 4'b0010, 1'b0, 1'b0, {13'h0007, 13'h0010, 4'b0010, 1'b0, 1'b0}};
    vecs[5] = '{13'h0F0F, 13'h1FFF, 4'b0010, 1'b0, 1'b1, {13'h0F0F, 13'h1FFF, 4'b0010, 1'b0, 1'b1}};

    // Reset state and d_wr passthrough while held in reset.
    clr_all = 1'b1;
    #12;
    check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
    check("rst_core_stall", {31'd0, core_stall}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    core_wr = 1'b1;
    #1;
    check("rst_d_wr_pass1", {31'd0, d_wr}, 32'd1);
    core_wr = 1'b0;
    #1;
    check("rst_d_wr_pass0", {31'd0, d_wr}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    clr_all = 1'b0;
    pulse_mon_clr();

    // All-clean flush.
    run_flush(0, -1, -1, cyc, busy_n, stall_diff);
    check("clean_done_latency", cyc, 32'd8193);
    check("clean_busy_cycles", busy_n, 32'd8193);
    check("clean_stall_eq_busy", stall_diff, 32'd0);
    check("clean_wb_valid_cnt", mon_wb, 32'd0);
    check("clean_d_wr_cnt", mon_dwr, 32'd0);
    check("clean_done_cnt", mon_done, 32'd1);

    // IDLE passthrough vectors.
    for (int i = 0; i < 6; i++) begin
      core_ra = vecs[i].ra; core_wa = vecs[i].wa; core_way = vecs[i].way;
      core_wr = vecs[i].wr; core_in = vecs[i].cin;
      #1;
      check($sformatf("pass_vec%0d", i), {d_ra, d_wa, d_way, d_wr, d_in}, vecs[i].exp);
      tick();
    end
    core_wr = 1'b0;
    core_ra = 13'd7;
    #1;
    check("idle_write_set7", {28'd0, d_rd}, 32'h4);
    core_wa = 13'd7; core_way = 4'b0100; core_in = 1'b0; core_wr = 1'b1;
    tick();
    core_wr = 1'b0;
    #1;
    check("idle_clear_set7", {28'd0, d_rd}, 32'h0);

    // Set 5 = 1010, ready tied high.
    preload(13'd5, 4'b1010);
    run_flush(0, -1, -1, cyc, busy_n, stall_diff);
    check("s5_latency", cyc, 32'd8197);
    check("s5_hs_count", hs_n, 32'd2);
    check("s5_hs0", {hs_set[0], hs_way[0]}, {17'd0, 13'd5, 2'd1});
    check("s5_hs1", {hs_set[1], hs_way[1]}, {17'd0, 13'd5, 2'd3});
    check("s5_cleared", {28'd0, arr[5]}, 32'h0);
    check("s5_neighbours", {24'd0, arr[4], arr[6]}, 32'h0);
    check("s5_d_wr_cnt", mon_dwr, 32'd2);
    check("s5_overlap", mon_overlap, 32'd0);

    // Set 8191 = 1111, ready low 10 cycles per request.
    preload(13'd8191, 4'b1111);
    run_flush(10, -1, -1, cyc, busy_n, stall_diff);
    check("s8191_latency", cyc, 32'd8241);
    check("s8191_hs_count", hs_n, 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("s8191_hs%0d", i), {hs_set[i], hs_way[i]}, {17'd0, 13'd8191, 2'(i)});
    check("s8191_stable", mon_unstable, 32'd0);
    check("s8191_wb_cycles", mon_wb, 32'd44);
    check("s8191_cleared", {28'd0, arr[8191]}, 32'h0);
    check("s8191_done_cnt", mon_done, 32'd1);
    check("s8191_overlap", mon_overlap, 32'd0);

    // Repeated flush_req and a core write while busy.
    run_flush(0, 100, 200, cyc, busy_n, stall_diff);
    check("dup_latency", cyc, 32'd8193);
    check("dup_done_cnt", mon_done, 32'd1);
    check("dup_d_wr_cnt", mon_dwr, 32'd0);
    check("busy_write_set7", {28'd0, arr[7]}, 32'h0);

    // Reset while a writeback is pending.
    preload(13'd3, 4'b0010);
    pulse_mon_clr();
    flush_req = 1'b1;
    wb_ready  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      flush_req = 1'b0;
      if (wb_valid) seen = 1'b1;
    end
    check("abort_reached_wb", {31'd0, seen}, 32'd1);
    check("abort_wb_set", {19'd0, wb_set}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("abort_busy", {31'd0, flush_busy}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_no_done", mon_done, 32'd0);
    check("abort_set3_kept", {28'd0, arr[3]}, 32'h2);
    run_flush(0, -1, -1, cyc, busy_n, stall_diff);
    check("after_abort_latency", cyc, 32'd8195);
    check("after_abort_hs", {hs_set[0], hs_way[0]}, {17'd0, 13'd3, 2'd1});
    check("after_abort_cleared", {28'd0, arr[3]}, 32'h0);
    check("after_abort_done_cnt", mon_done, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
